// File: rtl/hc595_rx.sv
// hc595_rx: decodes the 14-bit 74HC595 ds/shcp/stcp stream back into sel/seg (optional err_cnt via HC595_RX_ERR_CNT_EN)
module hc595_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 14
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       ds,
  input  logic       shcp,
  input  logic       stcp,
  input  logic       oe,
  output logic [5:0] sel,
  output logic [7:0] seg,
  output logic       frame_vld,
  output logic       frame_err,
  output logic [7:0] err_cnt
);
  logic [3:0]  sync [SYNC_STAGES];
  logic        ds_s, shcp_s, stcp_s, oe_s, shcp_p, stcp_p, shcp_r, stcp_r;
  logic [13:0] shift_reg, shift_nx, latch_reg;
  logic [3:0]  bit_cnt, cnt_nx;
  logic        take, upd, bad;
  logic [7:0]  seg_dec;

  assign {oe_s, stcp_s, shcp_s, ds_s} = sync[SYNC_STAGES-1];

  // all four lines share one chain depth so ds stays aligned with shcp
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      shcp_p <= 1'b0;
      stcp_p <= 1'b0;
    end else begin
      sync[0] <= {oe, stcp, shcp, ds};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      shcp_p <= shcp_s;
      stcp_p <= stcp_s;
    end

  // edge detect; a shift coincident with a latch is applied before the latch sees it
  always_comb begin
    shcp_r   = shcp_s & ~shcp_p;
    stcp_r   = stcp_s & ~stcp_p;
    shift_nx = shcp_r ? {ds_s, shift_reg[13:1]} : shift_reg;
    cnt_nx   = shcp_r ? ((bit_cnt == 4'd15) ? 4'd15 : 4'(bit_cnt + 4'd1)) : bit_cnt;
    take     = stcp_r && (cnt_nx != 4'd0);
  end

  // frame bit order: data[5:0] -> sel, data[6..13] -> seg[7..0]
  always_comb begin
    seg_dec = '0;
    for (int i = 0; i < 8; i++) seg_dec[7-i] = latch_reg[6+i];
  end

  // shifter, bit counter and storage latch; stcp with no bits shifted is the driver's start-up pulse
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      latch_reg <= '0;
      upd       <= 1'b0;
      bad       <= 1'b0;
    end else begin
      shift_reg <= shift_nx;
      bit_cnt   <= stcp_r ? 4'd0 : cnt_nx;
      upd       <= take;
      bad       <= take && (cnt_nx != 4'(FRAME_BITS));
      if (take) latch_reg <= shift_nx;
    end

  // registered outputs; oe blanks the display without disturbing the latch
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      sel       <= '0;
      seg       <= '0;
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sel       <= oe_s ? 6'd0 : latch_reg[5:0];
      seg       <= oe_s ? 8'd0 : seg_dec;
      frame_vld <= upd;
      frame_err <= bad;
    end

`ifdef HC595_RX_ERR_CNT_EN
  logic [7:0] err_q;
  // saturating count of malformed frames, cleared only by reset
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) err_q <= '0;
    else if (frame_err && err_q != 8'hFF) err_q <= err_q + 8'd1;
  assign err_cnt = err_q;
`else
  assign err_cnt = 8'd0;
`endif
endmodule
